lfsr_stream_engine: RTL and testbench
=====================================

LFSR_STREAM_ENGINE -- requirements
Module: lfsr_stream_engine

Interface
REQ-001 Parameter TAP_BASE, default 8'd130, data-memory address of tap-pattern entry 0.
REQ-002 Parameter TAP_COUNT, default 9, number of valid tap-pattern entries.
REQ-003 Clk  input  1  clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 TapSel  input  4  index into tap-pattern table.
REQ-007 Seed  input  7  initial LFSR state.
REQ-008 SrcBase  input  8  first source byte address.
REQ-009 DstBase  input  8  first destination byte address.
REQ-010 Length  input  7  byte count, 0..127.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 Done  output  1  one-cycle pulse at transfer end.
REQ-013 Err  output  1  high with Done when TapSel >= TAP_COUNT.
REQ-014 MemAddr  output  8  data-memory address.
REQ-015 MemWrEn  output  1  data-memory write enable.
REQ-016 MemWrData  output  8  data-memory write data.
REQ-017 MemRdData  input  8  data-memory read data, combinational from MemAddr in the same cycle.

Function
REQ-018 FSM states SHALL be IDLE, TAP, READ, WRITE, FIN.
REQ-019 IDLE: on Start, SHALL latch TapSel, Seed, SrcBase, DstBase, Length, clear index i, and go to FIN with Err set if TapSel >= TAP_COUNT, else go to TAP.
REQ-020 TAP: MemAddr = TAP_BASE + TapSel; SHALL latch MemRdData[6:0] as tap mask; next READ if Length != 0, else FIN.
REQ-021 READ: MemAddr = SrcBase + i (mod 256); SHALL latch MemRdData ^ {1'b0, lfsr}; next WRITE.
REQ-022 WRITE: MemAddr = DstBase + i (mod 256), MemWrEn = 1, MemWrData = latched byte; lfsr <= {lfsr[5:0], ^(lfsr & tap)}; i <= i + 1; next FIN if i + 1 == Length, else READ.
REQ-023 FIN: Done = 1 for exactly one cycle; next IDLE; Err SHALL be valid only while Done = 1.
REQ-024 MemWrEn SHALL be 0 in every state other than WRITE; MemAddr SHALL be 0 in IDLE and FIN.
REQ-025 Start while Busy SHALL be ignored and SHALL not be queued.
REQ-026 Latency Start to Done: 2 + 2*Length cycles for valid TapSel; 1 cycle for invalid TapSel.
REQ-027 Address arithmetic SHALL wrap modulo 256; overlapping source/destination regions are legal, processed in ascending i order.
REQ-028 Seed = 0 SHALL be legal: the LFSR stays 0 and the data is copied unchanged.

Reset
REQ-029 Reset SHALL force IDLE, Busy = 0, Done = 0, Err = 0, MemWrEn = 0, MemAddr = 0, MemWrData = 0, and clear lfsr, tap, i, and the latched byte.
REQ-030 Reset asserted mid-transfer SHALL abort at the next edge, with no further memory write.

Configuration
REQ-031 Macro LFSR_STREAM_PARITY_EN defined: MemWrData[7] SHALL be the even-parity bit of MemWrData[6:0].
REQ-032 Macro undefined: MemWrData[7] SHALL equal source byte bit 7.

Structure
REQ-033 Shared package lfsr_pkg SHALL hold the FSM state enum, TAP_BASE and TAP_COUNT defaults, and the LFSR next-state function.
REQ-034 Sub-module lfsr7_step SHALL hold the combinational LFSR step (state, tap -> next state) and be instantiated once.

Verification
REQ-035 Tap 0 = 0x60, Seed 0x01, Length 1, src 0x41 -> dst 0x40, Done 4 cycles after Start, Err 0.
REQ-036 Same setup, Length 2, src 0x41, 0x41 -> dst 0x40, 0x43 (LFSR 0x01 -> 0x02).
REQ-037 TapSel 9 -> Done + Err one cycle after Start; no MemWrEn pulse.
REQ-038 Length 0 -> Done 2 cycles after Start; no write; Start held high during Busy has no effect.
REQ-039 SrcBase 0xFF, DstBase 0xFE, Length 2 -> reads 0xFF, 0x00; writes 0xFE, 0xFF.
REQ-040 Reset after first WRITE of Length 4 -> Busy 0 next cycle; only one destination byte modified; with LFSR_STREAM_PARITY_EN, REQ-035 dst = 0xC0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR stream engine.
//   state_t           : engine FSM states
//   TAP_BASE_DEFAULT  : data-memory address of tap-pattern entry 0
//   TAP_COUNT_DEFAULT : number of valid tap-pattern entries
//   lfsr7_next()      : 7-bit Fibonacci LFSR step, shift left, feedback into bit 0
package lfsr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAP,
    S_READ,
    S_WRITE,
    S_FIN
  } state_t;

  localparam logic [7:0]  TAP_BASE_DEFAULT  = 8'd130;
  localparam int unsigned TAP_COUNT_DEFAULT = 9;

  function automatic logic [6:0] lfsr7_next(input logic [6:0] state,
                                            input logic [6:0] tap);
    return {state[5:0], ^(state & tap)};
  endfunction

endpackage

// File: rtl/lfsr7_step.sv
// Combinational single step of the 7-bit LFSR.
// Ports:
//   state      in  7  current LFSR state
//   tap        in  7  feedback tap mask
//   next_state out 7  state after one shift
module lfsr7_step
  import lfsr_pkg::*;
(
  input  logic [6:0] state,
  input  logic [6:0] tap,
  output logic [6:0] next_state
);

  always_comb begin
    next_state = lfsr7_next(state, tap);
  end

endmodule

// File: rtl/lfsr_stream_engine.sv
// LFSR stream engine: fetches a tap mask from data memory, then copies Length
// bytes from SrcBase to DstBase, XOR-ing each byte with a 7-bit LFSR stream.
// Optional macro LFSR_STREAM_PARITY_EN: when defined, bit 7 of each written
// byte is the even-parity bit of bits [6:0]; otherwise it is source bit 7.
// Ports:
//   Clk, Reset  clock and synchronous active-high reset
//   Start       one-cycle transfer request, sampled only in IDLE
//   TapSel      tap-pattern table index (>= TAP_COUNT reports Err)
//   Seed        initial LFSR state
//   SrcBase     first source byte address
//   DstBase     first destination byte address
//   Length      byte count 0..127
//   Busy        high whenever not IDLE
//   Done        one-cycle end-of-transfer pulse
//   Err         invalid TapSel, valid only with Done
//   MemAddr     data-memory address (0 in IDLE/FIN)
//   MemWrEn     data-memory write enable (WRITE only)
//   MemWrData   data-memory write data
//   MemRdData   data-memory read data, combinational from MemAddr
module lfsr_stream_engine
  import lfsr_pkg::*;
#(
  parameter logic [7:0]  TAP_BASE  = TAP_BASE_DEFAULT,
  parameter int unsigned TAP_COUNT = TAP_COUNT_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] TapSel,
  input  logic [6:0] Seed,
  input  logic [7:0] SrcBase,
  input  logic [7:0] DstBase,
  input  logic [6:0] Length,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic [7:0] MemAddr,
  output logic       MemWrEn,
  output logic [7:0] MemWrData,
  input  logic [7:0] MemRdData
);

  state_t     state;
  logic [6:0] lfsr;
  logic [6:0] tap;
  logic [6:0] idx;
  logic [6:0] len_q;
  logic [7:0] src_q;
  logic [7:0] dst_q;
  logic [7:0] data_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [7:0] addr_q;
  logic       wr_en_q;

  logic [6:0] lfsr_nxt;
  logic [6:0] idx_nxt;
  logic [7:0] xored;
  logic [7:0] wr_byte;
  logic       tap_invalid;

  lfsr7_step u_step (
    .state      (lfsr),
    .tap        (tap),
    .next_state (lfsr_nxt)
  );

  always_comb begin
    idx_nxt     = idx + 7'd1;
    tap_invalid = ({28'd0, TapSel} >= TAP_COUNT);
    xored       = MemRdData ^ {1'b0, lfsr};
`ifdef LFSR_STREAM_PARITY_EN
    wr_byte     = {^xored[6:0], xored[6:0]};
`else
    wr_byte     = xored;
`endif
  end

  // Outputs are registered: every address is loaded on the edge that enters
  // the state using it, so the combinational read data is valid in that state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      lfsr    <= '0;
      tap     <= '0;
      idx     <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          addr_q <= '0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          if (Start) begin
            lfsr   <= Seed;
            src_q  <= SrcBase;
            dst_q  <= DstBase;
            len_q  <= Length;
            idx    <= '0;
            busy_q <= 1'b1;
            if (tap_invalid) begin
              state  <= S_FIN;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state  <= S_TAP;
              addr_q <= TAP_BASE + {4'd0, TapSel};
            end
          end
        end
        S_TAP: begin
          tap <= MemRdData[6:0];
          if (len_q != '0) begin
            state  <= S_READ;
            addr_q <= src_q + {1'b0, idx};
          end else begin
            state  <= S_FIN;
            done_q <= 1'b1;
            addr_q <= '0;
          end
        end
        S_READ: begin
          data_q  <= wr_byte;
          state   <= S_WRITE;
          addr_q  <= dst_q + {1'b0, idx};
          wr_en_q <= 1'b1;
        end
        S_WRITE: begin
          lfsr <= lfsr_nxt;
          idx  <= idx_nxt;
          if (idx_nxt == len_q) begin
            state  <= S_FIN;
            done_q <= 1'b1;
            addr_q <= '0;
          end else begin
            state  <= S_READ;
            addr_q <= src_q + {1'b0, idx_nxt};
          end
        end
        S_FIN: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          err_q  <= 1'b0;
          addr_q <= '0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          err_q  <= 1'b0;
          addr_q <= '0;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign MemAddr   = addr_q;
  assign MemWrEn   = wr_en_q;
  assign MemWrData = data_q;

endmodule

// File: tb/tb_lfsr_stream_engine.sv
// Directed self-checking bench for lfsr_stream_engine with a 256-byte
// behavioural data memory holding the tap table at 130..138.
module tb_lfsr_stream_engine;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] TapSel = '0;
  logic [6:0] Seed = '0;
  logic [7:0] SrcBase = '0;
  logic [7:0] DstBase = '0;
  logic [6:0] Length = '0;
  logic       Busy, Done, Err, MemWrEn;
  logic [7:0] MemAddr, MemWrData, MemRdData;

  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  int         wr_count = 0;
  logic [7:0] wr_log [8];

  int vectors = 0;
  int miscompares = 0;

  lfsr_stream_engine #(.TAP_BASE(8'd130), .TAP_COUNT(9)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .TapSel    (TapSel),
    .Seed      (Seed),
    .SrcBase   (SrcBase),
    .DstBase   (DstBase),
    .Length    (Length),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err),
    .MemAddr   (MemAddr),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData),
    .MemRdData (MemRdData)
  );

  always #5 Clk = ~Clk;

  assign MemRdData = mem[MemAddr];

  always @(posedge Clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (MemWrEn) begin
      mem[MemAddr] <= MemWrData;
      if (wr_count < 8) wr_log[wr_count] <= MemAddr;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge Clk);
    ld_en = 1'b0;
  endtask

  // Pulses (or holds) Start and counts cycles until Done; -1 on timeout.
  task automatic run(input logic [3:0] ts, input logic [6:0] sd, input logic [7:0] sb,
                     input logic [7:0] db, input logic [6:0] ln, input bit hold,
                     output int cyc, output logic err_seen);
    @(negedge Clk);
    TapSel = ts; Seed = sd; SrcBase = sb; DstBase = db; Length = ln; Start = 1'b1;
    cyc = -1; err_seen = 1'bx;
    for (int n = 1; n <= 300; n++) begin
      @(negedge Clk);
      if (!hold) Start = 1'b0;
      if (Done) begin
        cyc = n; err_seen = Err;
        break;
      end
    end
    Start = 1'b0;
  endtask

  localparam logic [7:0] T1_DST  = `ifdef LFSR_STREAM_PARITY_EN 8'hC0 `else 8'h40 `endif;
  localparam logic [7:0] T2_DST1 = `ifdef LFSR_STREAM_PARITY_EN 8'hC3 `else 8'h43 `endif;

  initial begin
    int cyc;
    logic e;
    int wc0;

    repeat (3) @(negedge Clk);
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    check("reset_err", Err, 1'b0);
    check("reset_wren", MemWrEn, 1'b0);
    check("reset_addr", MemAddr, 8'h00);
    check("reset_wdata", MemWrData, 8'h00);
    Reset = 1'b0;

    poke(8'd130, 8'h60);
    poke(8'd131, 8'h11);
    poke(8'd132, 8'h7F);
    poke(8'h41, 8'h41);
    poke(8'h40, 8'hEE);
    poke(8'h50, 8'h41);
    poke(8'h51, 8'h41);
    poke(8'hFF, 8'h3C);
    poke(8'h00, 8'h81);
    poke(8'h10, 8'hA5);
    poke(8'h11, 8'h5A);
    poke(8'h12, 8'hFF);
    for (int k = 0; k < 4; k++) poke(8'h30 + 8'(k), 8'h41);
    for (int k = 0; k < 4; k++) poke(8'h70 + 8'(k), 8'hEE);

    // Single byte, tap 0x60, seed 0x01
    wc0 = wr_count;
    run(4'd0, 7'h01, 8'h41, 8'h40, 7'd1, 1'b0, cyc, e);
    check("len1_latency", cyc, 4);
    check("len1_err", e, 1'b0);
    check("len1_addr_fin", MemAddr, 8'h00);
    @(negedge Clk);
    check("len1_done_pulse", Done, 1'b0);
    check("len1_busy_after", Busy, 1'b0);
    check("len1_writes", wr_count - wc0, 1);
    check("len1_dst", mem[8'h40], T1_DST);

    // Two bytes, LFSR 0x01 -> 0x02
    wc0 = wr_count;
    run(4'd0, 7'h01, 8'h50, 8'h60, 7'd2, 1'b0, cyc, e);
    check("len2_latency", cyc, 6);
    check("len2_dst0", mem[8'h60], T1_DST);
    check("len2_dst1", mem[8'h61], T2_DST1);
    check("len2_writes", wr_count - wc0, 2);

    // Invalid TapSel
    wc0 = wr_count;
    run(4'd9, 7'h01, 8'h41, 8'h40, 7'd3, 1'b0, cyc, e);
    check("badtap_latency", cyc, 1);
    check("badtap_err", e, 1'b1);
    check("badtap_addr", MemAddr, 8'h00);
    @(negedge Clk);
    check("badtap_err_clear", Err, 1'b0);
    check("badtap_no_write", wr_count - wc0, 0);

    // Length 0 with Start held high throughout Busy
    wc0 = wr_count;
    run(4'd1, 7'h05, 8'h41, 8'h40, 7'd0, 1'b1, cyc, e);
    check("len0_latency", cyc, 2);
    check("len0_err", e, 1'b0);
    @(negedge Clk);
    check("len0_idle1", Busy, 1'b0);
    @(negedge Clk);
    check("len0_idle2", Busy, 1'b0);
    check("len0_no_done", Done, 1'b0);
    check("len0_no_write", wr_count - wc0, 0);

    // Address wrap with overlapping regions, tap 0x7F, seed 0x05 -> 0x0A
    wc0 = wr_count;
    run(4'd2, 7'h05, 8'hFF, 8'hFE, 7'd2, 1'b0, cyc, e);
    check("wrap_latency", cyc, 6);
    check("wrap_waddr0", wr_log[wc0], 8'hFE);
    check("wrap_waddr1", wr_log[wc0 + 1], 8'hFF);
    check("wrap_dst0", mem[8'hFE], 8'h39);
    check("wrap_dst1", mem[8'hFF], 8'h8B);

    // Seed 0 copies unchanged
    run(4'd0, 7'h00, 8'h10, 8'h20, 7'd3, 1'b0, cyc, e);
    check("seed0_latency", cyc, 8);
    check("seed0_dst0", mem[8'h20], 8'hA5);
    check("seed0_dst1", mem[8'h21], 8'h5A);
    check("seed0_dst2", mem[8'h22], 8'hFF);

    // Reset after first write of a 4-byte transfer
    wc0 = wr_count;
    @(negedge Clk);
    TapSel = 4'd0; Seed = 7'h01; SrcBase = 8'h30; DstBase = 8'h70; Length = 7'd4;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cyc = -1;
    for (int n = 0; n < 20; n++) begin
      if (MemWrEn) begin
        cyc = n;
        break;
      end
      @(negedge Clk);
    end
    check("abort_saw_write", (cyc >= 0), 1'b1);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_busy", Busy, 1'b0);
    check("abort_wren", MemWrEn, 1'b0);
    check("abort_addr", MemAddr, 8'h00);
    check("abort_wdata", MemWrData, 8'h00);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("abort_writes", wr_count - wc0, 1);
    check("abort_dst0", mem[8'h70], T1_DST);
    check("abort_dst1", mem[8'h71], 8'hEE);
    check("abort_idle", Busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
